mem_access_unit: RTL
====================

# mem_access_unit

Parametrised load/store unit for the data stage: accepts one load or store per request, aligns write data and byte strobes onto an XLEN-wide data bus, and extracts and sign- or zero-extends load data into an XLEN-wide result. Accesses that cross an XLEN-aligned boundary are split into two bus beats. Sits between the execute/data stage and the data-memory port, with valid/ready handshakes on both sides and one outstanding bus transaction.

## Interface
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- NB (derived), XLEN/8, bytes per bus word; OFF_W = log2(NB).

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal size, qualified by resp_valid.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus request accepted when bus_valid && bus_ready.
- bus_we  out  1  write beat.
- bus_addr  out  ADDR_W  NB-aligned word address.
- bus_wstrb  out  NB  byte-lane write enables.
- bus_wdata  out  XLEN  lane-aligned write data.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data.

## Operation
- funct3 decode: [1:0] gives size = 1 << funct3[1:0] bytes; [2] = 1 means zero-extend (loads only).
- Legal sizes: 000/001/010 always. 011 (D) only when XLEN=64. 110 (LWU) only when XLEN=64 and only for loads.
- Illegal funct3, including any store with funct3[2]=1: no bus activity; resp_valid with resp_err=1, resp_rdata=0.
- Let off = addr[OFF_W-1:0]. The access is split iff off + size > NB.
- Beat 0: bus_addr = addr with low OFF_W bits cleared.
  - wstrb = (((1<<size)-1) << off) truncated to NB bits.
  - wdata = req_wdata << 8*off.
- Beat 1: bus_addr = beat0 addr + NB, modulo 2^ADDR_W (wraps to 0).
  - wstrb = the bits shifted out above NB.
  - wdata = req_wdata >> 8*(NB-off).
- Load result: take {beat1_rdata, beat0_rdata} >> 8*off and keep the low size bytes.
  - Extension bit is bit 8*size-1 of the extracted value when funct3[2]=0; otherwise 0.
- Load beats present wstrb=0 and bus_we=0.
- Request fields are registered at acceptance; bus outputs derive only from registered state.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE→ISSUE0 on an accepted legal request.
  - IDLE→RESP on an accepted illegal request.
  - ISSUEn on bus handshake: load → WAITn; store → ISSUE1 if split and n=0, else RESP.
  - WAITn on bus_rvalid: capture rdata into beat n; then → ISSUE1 if split and n=0, else RESP.
  - RESP→IDLE unconditionally.
- bus_valid is high only in ISSUEn. While bus_valid=1 and bus_ready=0, bus_addr, bus_we, bus_wstrb and bus_wdata are held stable.
- bus_rvalid outside WAITn is ignored.

## Timing
- Reset values: req_ready=0 while rst_n=0, then 1 in IDLE.
- Other outputs in reset: resp_valid=0, resp_rdata=0, resp_err=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0.
- req_ready = rst_n && state==IDLE. Back-to-back requests are therefore impossible; the minimum spacing is one IDLE cycle after RESP.
- Aligned load with bus_ready=1 and bus_rvalid one cycle after acceptance:
  - request accepted at edge 0; bus_valid in cycle 1; rdata captured at edge 2; resp_valid in cycle 3.
  - Each stall cycle adds one.
- Split load adds 2 cycles.
- Aligned store: resp_valid in cycle 2. Split store: resp_valid in cycle 3.
- Illegal request: resp_valid in cycle 1.
- rst_n low mid-operation: state is IDLE and bus_valid=0 from the next edge.
  - No resp_valid for the aborted request.
  - A bus_rvalid arriving late is discarded.

## Structure
- Package mem_pkg holds:
  - funct3 localparams (LB..LWU, SB..SD);
  - the size_t enum (BYTE, HALF, WORD, DOUBLE);
  - the state_t enum;
  - function legal_access(funct3, we, XLEN).
- Sub-module mem_lane_align (combinational, parametrised by XLEN) computes beat strobes and data for both beats from off, size and wdata.
- Load extraction and extension stay in the top module.

## Test plan
- XLEN=32, LB at 0x1003, bus_rdata=0x80112233 → resp_rdata=0xFFFFFF80; LBU at the same address → 0x00000080.
- XLEN=32, LH at 0x1002, bus_rdata=0x8001AAAA → resp_rdata=0xFFFF8001 (sign taken from bit 15).
- XLEN=32, LW at 0x1003:
  - beat 0 at 0x1000 returns 0xDDCCBBAA; beat 1 at 0x1004 returns 0x44332211;
  - → resp_rdata=0x332211DD in cycle 5.
- XLEN=32, SW 0x12345678 at 0x1006:
  - beat 0: addr 0x1004, wstrb 1100, wdata 0x56780000;
  - beat 1: addr 0x1008, wstrb 0011, wdata 0x00001234.
- bus_ready held low 4 cycles → bus fields stable throughout. Reset asserted in WAIT0 with bus_rvalid the next cycle → IDLE, no resp_valid.
- XLEN=32 funct3=011 → resp_err=1, bus_valid never high. LW at 0xFFFFFFFE → beat 1 bus_addr=0x00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the data-stage load/store unit.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} size_t;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  function automatic logic legal_access(input logic [2:0] funct3, input logic we, input int xlen);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (funct3)
        SB, SH, SW: ok = 1'b1;
        SD:         ok = (xlen == 64);
        default:    ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        LD, LWU:              ok = (xlen == 64);
        default:              ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus port: the unit is the master, the memory the slave.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NB = XLEN / 8;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_wstrb;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane placement of store data and strobes for both beats of an access.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] off,
  input  size_t            size,
  input  logic [XLEN-1:0]  wdata,
  output logic [NB-1:0]    strb0,
  output logic [NB-1:0]    strb1,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1
);
  logic [2*NB-1:0]   ones;
  logic [2*NB-1:0]   mask;
  logic [2*XLEN-1:0] wide;

  // Shifting into a double-width vector yields beat 1 as the spill-over half.
  always_comb begin
    ones   = ((2*NB)'(1) << (4'd1 << size)) - (2*NB)'(1);
    mask   = ones << off;
    wide   = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    strb0  = mask[NB-1:0];
    strb1  = mask[2*NB-1:NB];
    wdata0 = wide[XLEN-1:0];
    wdata1 = wide[2*XLEN-1:XLEN];
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: splits misaligned accesses into two bus beats and extends load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  mem_access_unit_if.master bus
);
  state_t            state, state_n;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata0_q, rdata1_q;

  logic              accept, legal, split;
  logic [OFF_W-1:0]  off;
  size_t             size;
  logic [4:0]        ends;
  logic [ADDR_W-1:0] base;
  logic [NB-1:0]     strb0, strb1;
  logic [XLEN-1:0]   wd0, wd1;
  logic [XLEN-1:0]   val, keep, topbit, ld_ext;
  logic              sgn;

  assign legal  = legal_access(req_funct3, req_we, XLEN);
  assign accept = req_valid && req_ready;
  assign off    = addr_q[OFF_W-1:0];
  assign size   = size_t'(f3_q[1:0]);
  assign ends   = 5'(off) + (5'd1 << size);
  assign split  = ends > 5'(NB);
  assign base   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off    (off),
    .size   (size),
    .wdata  (wdata_q),
    .strb0  (strb0),
    .strb1  (strb1),
    .wdata0 (wd0),
    .wdata1 (wd1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q     <= req_we;
        err_q    <= !legal;
        f3_q     <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state == WAIT0 && bus.bus_rvalid) rdata0_q <= bus.bus_rdata;
      if (state == WAIT1 && bus.bus_rvalid) rdata1_q <= bus.bus_rdata;
    end
  end

  // Keep mask is all-ones when the shift reaches XLEN, so no size clamp is needed.
  always_comb begin
    val    = XLEN'({rdata1_q, rdata0_q} >> {off, 3'b000});
    keep   = (XLEN'(1) << (7'd8 << size)) - XLEN'(1);
    topbit = keep & ~(keep >> 1);
    sgn    = !f3_q[2] && |(val & topbit);
    ld_ext = sgn ? (val | ~keep) : (val & keep);
  end

  always_comb begin
    state_n        = state;
    req_ready      = rst_n && (state == IDLE);
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    bus.bus_valid  = 1'b0;
    bus.bus_we     = 1'b0;
    bus.bus_addr   = '0;
    bus.bus_wstrb  = '0;
    bus.bus_wdata  = '0;
    case (state)
      IDLE: if (req_valid) state_n = legal ? ISSUE0 : RESP;
      ISSUE0: begin
        bus.bus_valid = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = base;
        bus.bus_wstrb = we_q ? strb0 : '0;
        bus.bus_wdata = wd0;
        if (bus.bus_ready) state_n = !we_q ? WAIT0 : (split ? ISSUE1 : RESP);
      end
      WAIT0: if (bus.bus_rvalid) state_n = split ? ISSUE1 : RESP;
      ISSUE1: begin
        bus.bus_valid = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = base + ADDR_W'(NB);
        bus.bus_wstrb = we_q ? strb1 : '0;
        bus.bus_wdata = wd1;
        if (bus.bus_ready) state_n = we_q ? RESP : WAIT1;
      end
      WAIT1: if (bus.bus_rvalid) state_n = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ld_ext;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
